btn_debounce: RTL
=================

Name: btn_debounce

Overview:
- Per-button conditioning stage between the raw ULX3S `btn[6:0]` pads and the LED/user logic.
- Synchronises each button and inverts the active-low ones to active-high.
- Debounces each channel with a per-channel stability counter.
- Emits the clean level plus single-cycle press/release strobes that downstream counters and LED logic consume.

Parameters:
- WIDTH, 7, number of button channels.
- INV_MASK, 7'b0000001, bit i = 1 means raw input i is active-low and is inverted before synchronisation. `btn[0]` (PWR) is active-low.
- DEBOUNCE_TICKS, 250000, consecutive stable cycles required to accept a change (10 ms at 25 MHz). Must be >= 2.
- CNT_W, 18, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_TICKS.
- REPEAT_DELAY, 12500000, hold cycles before the first auto-repeat (500 ms). Used only with the optional feature.
- REPEAT_PERIOD, 2500000, cycles between subsequent auto-repeats (100 ms). Used only with the optional feature.

Ports:
- clk_25mhz  input  1  system clock, 25 MHz.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  WIDTH  raw, asynchronous button pads.
- btn_level  output  WIDTH  debounced level, active-high (1 = pressed).
- btn_press  output  WIDTH  1-cycle strobe on an accepted 0->1 of `btn_level`.
- btn_release  output  WIDTH  1-cycle strobe on an accepted 1->0 of `btn_level`.

Behaviour:
- **Reset (rst_n low):**
  - Asynchronous clear of all sync flops, counters, `btn_level`, `btn_press` and `btn_release` to 0.
  - Deassertion takes effect on the next clk_25mhz edge.
  - Reset mid-count discards the partial count; a held button is re-accepted only after a full DEBOUNCE_TICKS window following reset release.
- **Input conditioning, per channel i:** `x = btn[i] ^ INV_MASK[i]`, passed through a 2-flop synchroniser: `s1 <= x`, `s2 <= s1`.
- **Debounce, per channel, independent:**
  - If `s2 == btn_level[i]`: counter cleared to 0.
  - If `s2 != btn_level[i]` and counter < DEBOUNCE_TICKS-1: counter increments.
  - If `s2 != btn_level[i]` and counter == DEBOUNCE_TICKS-1: on that edge `btn_level[i]` toggles, counter clears, and the matching strobe (press for 0->1, release for 1->0) is registered high for exactly that one cycle.
  - Any glitch back to the accepted level before the count completes restarts the window from 0.
- **Latency:**
  - A clean step on `btn` appears on `btn_level` 2 + DEBOUNCE_TICKS cycles after the first clock edge that samples it.
  - The strobe is high in the same cycle `btn_level` first shows the new value.
- **Strobes:**
  - `btn_press` and `btn_release` of one channel are never high together.
  - Channels may strobe in the same cycle.
  - Strobes are 0 in all other cycles.
- **Counter:** saturating compare, no wrap. The counter never exceeds DEBOUNCE_TICKS-1.
- All outputs are registered; no combinational path from `btn` to any output.

Optional Feature:
- Macro: BTN_DEBOUNCE_REPEAT_EN.
- **Defined:** each channel gets a hold counter (width ceil(log2(REPEAT_DELAY+1))).
  - Cleared while `btn_level[i]` = 0 and on the accepted-press cycle.
  - After REPEAT_DELAY cycles of continuous hold following the press strobe, `btn_press[i]` pulses once more.
  - Thereafter it pulses every REPEAT_PERIOD cycles while held.
  - Release stops repeats immediately; no repeat pulse occurs in the release cycle.
  - The hold counter resets asynchronously with `rst_n`.
- **Undefined:** no repeat logic is synthesised, and `btn_press` pulses only on accepted edges.

Test Plan (bench overrides: DEBOUNCE_TICKS=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, WIDTH=7, INV_MASK=7'b0000001):
- **Reset:** hold rst_n=0, btn=7'b0000000 (ch0 reads as pressed because it is inverted) -> all outputs 0 during reset. After release, `btn_level[0]` rises and `btn_press[0]` pulses once exactly 6 cycles after the first sampling edge.
- **Clean press:** btn[1] 0->1 held -> `btn_level[1]`=1 and `btn_press[1]`=1 for one cycle at sampling edge +6. `btn_release` stays 0.
- **Bounce:** btn[2] toggles 1,0,1,0 on alternate cycles, then holds 1 -> no strobe during the bounce. `btn_press[2]` pulses once, 6 cycles after the final 0->1 sample.
- **Release and simultaneity:** release btn[1] and press btn[3] on the same edge -> `btn_release[1]` and `btn_press[3]` both high in the same cycle. Levels update together.
- **Reset mid-count:** btn[4] goes high, rst_n pulsed low 2 cycles later while still held -> no strobe before reset. After release, the full 6-cycle latency applies again.
- **Repeat (BTN_DEBOUNCE_REPEAT_EN defined):** hold btn[5] for 30 cycles after acceptance -> `btn_press[5]` pulses at +0, +10, +13, +16, ... Pulses stop on the release cycle. With the macro undefined -> only the +0 pulse.

Source files
------------

// File: rtl/btn_debounce_if.sv
// Button bus between the ULX3S pads and the debounce stage.
// master: pad/stimulus side, slave: the debouncer.
interface btn_debounce_if #(
  parameter int WIDTH = 7
);
  logic [WIDTH-1:0] btn;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (output btn, input btn_level, btn_press, btn_release);
  modport slave  (input btn, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: per-channel sync, polarity fix-up, debounce and press/release
// strobes for the ULX3S buttons.
// Optional auto-repeat on btn_press: define BTN_DEBOUNCE_REPEAT_EN.
module btn_debounce #(
  parameter int               WIDTH          = 7,
  parameter logic [WIDTH-1:0] INV_MASK       = WIDTH'(1),
  parameter int               DEBOUNCE_TICKS = 250000,
  parameter int               CNT_W          = 18,
  parameter int               REPEAT_DELAY   = 12500000,
  parameter int               REPEAT_PERIOD  = 2500000
) (
  input  logic           clk_25mhz,
  input  logic           rst_n,
  btn_debounce_if.slave  bus
);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_TICKS < 2 || (2 ** CNT_W) <= DEBOUNCE_TICKS ||
      REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_cfg
    $error("btn_debounce: illegal parameter combination");
  end

  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] lvl_v, prs_v, rel_v;

  // Two-flop synchroniser; active-low pads are flipped before the first flop.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn ^ INV_MASK;
      s2 <= s1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    logic [CNT_W-1:0] cnt;
    logic             lvl, prs, rel;
    logic             accept;
    logic             rpt;

    // Last cycle of an unbroken mismatch window: the new level is taken.
    assign accept = (s2[gi] != lvl) && (cnt == CNT_W'(DEBOUNCE_TICKS - 1));

    // Stability counter, accepted level and one-cycle edge strobes.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
      end else begin
        prs <= rpt;
        rel <= 1'b0;
        if (s2[gi] == lvl) begin
          cnt <= '0;
        end else if (accept) begin
          lvl <= ~lvl;
          cnt <= '0;
          prs <= ~lvl;
          rel <= lvl;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

`ifdef BTN_DEBOUNCE_REPEAT_EN
    localparam int HC_W = $clog2(REPEAT_DELAY + 1);
    logic [HC_W-1:0] hc;

    // Hold timer: runs while pressed; after the first repeat it is rewound so
    // later repeats land every REPEAT_PERIOD cycles.
    always_ff @(posedge clk_25mhz or negedge rst_n) begin
      if (!rst_n) begin
        hc <= '0;
      end else if (!lvl || accept) begin
        hc <= '0;
      end else if (hc == HC_W'(REPEAT_DELAY - 1)) begin
        hc <= HC_W'(REPEAT_DELAY - REPEAT_PERIOD);
      end else begin
        hc <= hc + HC_W'(1);
      end
    end

    // No repeat in the cycle the release is accepted.
    assign rpt = lvl && !accept && (hc == HC_W'(REPEAT_DELAY - 1));
`else
    assign rpt = 1'b0;
`endif

    assign lvl_v[gi] = lvl;
    assign prs_v[gi] = prs;
    assign rel_v[gi] = rel;
  end

  assign bus.btn_level   = lvl_v;
  assign bus.btn_press   = prs_v;
  assign bus.btn_release = rel_v;

endmodule
